// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the alu_seq execute-stage ALU.
//   OPC_W          opcode width
//   OP_AND..OP_MUL opcode encodings (ADD=011 and SLL=001 match the old ALU)
//   state_e        top-level sequencer states
package alu_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_AND = 3'b000;
    localparam logic [OPC_W-1:0] OP_SLL = 3'b001;
    localparam logic [OPC_W-1:0] OP_OR  = 3'b010;
    localparam logic [OPC_W-1:0] OP_ADD = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_SRL = 3'b101;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b110;
    localparam logic [OPC_W-1:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one multiplier bit
// per cycle. Only exists when ALU_MUL_EN is defined.
//   clk, rst  clock, synchronous active-high reset
//   start     latch a/b, clear the bit counter and begin
//   a, b      WIDTH-bit operands
//   done      high in the cycle the last bit is folded in (counter = WIDTH-1)
//   product   full 2*WIDTH-bit product, valid while done is high
`ifdef ALU_MUL_EN
module alu_mul_iter #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               busy_q;

    // product is the accumulator with the current bit already added, so the
    // final value is available combinationally in the done cycle.
    assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= done ? '0 : cnt_q + 1'b1;
            busy_q   <= !done;
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit, 8-op handshaked ALU with registered result and flags.
// Optional feature macro: ALU_MUL_EN (iterative multiplier for opcode 111;
// when undefined, opcode 111 returns 0 with err=1 in one cycle).
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (in_ready never looks at in_valid)
//   alu_ctrl            opcode, inp1/inp2 operands
//   out_valid/out_ready result handshake
//   alu_result, zero, carry, err  registered result and flags
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_SH = WIDTH'(WIDTH - 1);

    state_e             state_q, state_d;
    logic               vld_q, vld_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, carry_q, carry_d, err_q, err_d;
    logic               wr, accept, mul_go, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    // ---------------- single-cycle datapath ----------------
    logic             shift_ovf;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_err;

    // Any inp2 >= WIDTH shifts everything out; below that the low SHAMT_W
    // bits hold the whole amount, so the barrel shifter can stay narrow.
    assign shift_ovf = inp2 > MAX_SH;
    assign shamt     = inp2[SHAMT_W-1:0];
    assign sum       = {1'b0, inp1} + {1'b0, inp2};
    assign diff      = {1'b0, inp1} - {1'b0, inp2};   // msb = borrow

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (alu_ctrl)
            OP_AND:  alu_res = inp1 & inp2;
            OP_SLL:  alu_res = shift_ovf ? '0 : inp1 << shamt;
            OP_OR:   alu_res = inp1 | inp2;
            OP_ADD:  {alu_carry, alu_res} = sum;
            OP_XOR:  alu_res = inp1 ^ inp2;
            OP_SRL:  alu_res = shift_ovf ? '0 : inp1 >> shamt;
            OP_SUB:  {alu_carry, alu_res} = diff;
            // Only reaches the output register when there is no multiplier.
            default: alu_err = 1'b1;
        endcase
    end

    // ---------------- handshake ----------------
    assign in_ready = (state_q == ST_IDLE) && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    assign mul_go = accept && (alu_ctrl == OP_MUL);

    alu_mul_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_go),
        .a       (inp1),
        .b       (inp2),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign mul_go   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    // ---------------- sequencer ----------------
    always_comb begin
        state_d = state_q;
        wr      = 1'b0;
        res_d   = alu_res;
        carry_d = alu_carry;
        err_d   = alu_err;
        case (state_q)
            ST_IDLE: begin
                if (mul_go)      state_d = ST_MUL;
                else if (accept) wr = 1'b1;
            end
            ST_MUL: begin
                // Slot is guaranteed empty here: acceptance needed it empty
                // or draining, and nothing was written at acceptance.
                if (mul_done) begin
                    state_d = ST_IDLE;
                    wr      = 1'b1;
                    res_d   = mul_prod[WIDTH-1:0];
                    carry_d = |mul_prod[2*WIDTH-1:WIDTH];
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A write wins over a same-edge consume, keeping out_valid high.
        vld_d = wr | (vld_q & ~out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            if (wr) begin
                res_q   <= res_d;
                zero_q  <= (res_d == '0);
                carry_q <= carry_d;
                err_q   <= err_d;
            end
        end
    end

    assign out_valid  = vld_q;
    assign alu_result = res_q;
    assign zero       = zero_q;
    assign carry      = carry_q;
    assign err        = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test-plan cases plus randomized traffic, checked
// against a transaction-level model (slot contents + MUL cycles remaining).
module tb_alu_seq;

    localparam int W = 8;
    localparam int M = 1 << W;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic         in_ready, out_valid, zero, carry, err;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] inp1, inp2, alu_result;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ctrl   (alu_ctrl),
        .inp1       (inp1),
        .inp2       (inp2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero       (zero),
        .carry      (carry),
        .err        (err)
    );

    int errs = 0, checks = 0;

    // model state
    bit m_vld, m_zero, m_carry, m_err;
    int m_res, mul_left, p_res;
    bit p_carry;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vld = 0; m_res = 0; m_zero = 1; m_carry = 0; m_err = 0; mul_left = 0;
    endtask

    // Behavioural meaning of each opcode, plain integer arithmetic.
    task automatic ref_op(input int op, input int a, input int b,
                          output int r, output bit c, output bit e);
        int s;
        r = 0; c = 0; e = 0;
        case (op)
            0: r = a & b;
            1: r = (b >= W) ? 0 : (a * (1 << b)) % M;
            2: r = a | b;
            3: begin s = a + b; r = s % M; c = (s >= M); end
            4: r = a ^ b;
            5: r = (b >= W) ? 0 : a / (1 << b);
            6: begin r = (a - b + M) % M; c = (a < b); end
            default: begin
                if (MUL_EN) begin s = a * b; r = s % M; c = (s >= M); end
                else e = 1;
            end
        endcase
    endtask

    // One clock: drive at negedge, check against model, advance model at posedge.
    task automatic step(bit r, bit v, int op, int a, int b, bit ordy);
        bit mrdy, wr;
        int rr;
        bit rc, re;
        logic [31:0] av, bv;
        @(negedge clk);
        av = a; bv = b;
        rst = r; in_valid = v; alu_ctrl = 3'(op);
        inp1 = av[W-1:0]; inp2 = bv[W-1:0]; out_ready = ordy;
        #1;
        mrdy = (mul_left == 0) && (!m_vld || ordy);
        check("in_ready",  in_ready,   mrdy);
        check("out_valid", out_valid,  m_vld);
        check("result",    alu_result, m_res);
        check("zero",      zero,       m_zero);
        check("carry",     carry,      m_carry);
        check("err",       err,        m_err);
        @(posedge clk);
        if (r) model_reset();
        else begin
            wr = 0; rr = 0; rc = 0; re = 0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin wr = 1; rr = p_res; rc = p_carry; end
            end else if (v && mrdy) begin
                ref_op(op, a, b, rr, rc, re);
                if (op == 7 && MUL_EN) begin mul_left = W; p_res = rr; p_carry = rc; end
                else wr = 1;
            end
            if (wr) begin
                m_vld = 1; m_res = rr; m_zero = (rr == 0); m_carry = rc; m_err = re;
            end else if (m_vld && ordy) m_vld = 0;
        end
    endtask

    task automatic idle(bit ordy);
        step(0, 0, 0, 0, 0, ordy);
    endtask

    // Constant expectations straight from the test plan, just after an edge.
    task automatic expect_out(string tag, bit ov, int res, bit c, bit z, bit e);
        #2;
        check({tag, ".valid"}, out_valid,  ov);
        check({tag, ".res"},   alu_result, res);
        check({tag, ".carry"}, carry,      c);
        check({tag, ".zero"},  zero,       z);
        check({tag, ".err"},   err,        e);
    endtask

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; alu_ctrl = '0; inp1 = '0; inp2 = '0;
        repeat (2) @(posedge clk);
        model_reset();
        expect_out("reset", 0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 0;
        #1 check("reset.in_ready", in_ready, 1);

        step(0, 1, 3, 200, 100, 1); expect_out("add", 1, 44, 1, 0, 0);
        step(0, 1, 6, 5, 7, 1);     expect_out("sub", 1, 254, 1, 0, 0);
        step(0, 1, 1, 1, 3, 1);     expect_out("sll3", 1, 8, 0, 0, 0);
        step(0, 1, 1, 1, 9, 1);     expect_out("sll9", 1, 0, 0, 1, 0);
        step(0, 1, 5, 128, 7, 1);   expect_out("srl7", 1, 1, 0, 0, 0);

        if (MUL_EN) begin
            step(0, 1, 7, 15, 17, 1);
            for (int i = 0; i < W; i++) begin
                idle(1);
                if (i == W - 2) #2 check("mul.early", out_valid, 0);
            end
            expect_out("mul255", 1, 255, 0, 0, 0);
            idle(1);
            step(0, 1, 7, 16, 16, 1);
            for (int i = 0; i < W; i++) idle(1);
            expect_out("mul256", 1, 0, 1, 1, 0);
        end else begin
            step(0, 1, 7, 5, 5, 1);        expect_out("op7", 1, 0, 0, 1, 1);
            step(0, 1, 0, 'hF0, 'h3C, 1);  expect_out("and", 1, 'h30, 0, 0, 0);
        end

        // backpressure
        idle(1);
        step(0, 1, 3, 3, 4, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2, 1, 2, 0);
        expect_out("hold", 1, 7, 0, 0, 0);
        step(0, 1, 4, 'hF0, 'h0F, 1);  expect_out("drain", 1, 'hFF, 0, 0, 0);

        // reset in the middle of a MUL
        if (MUL_EN) begin
            idle(1);
            step(0, 1, 7, 9, 9, 1);
            repeat (3) idle(1);
            step(1, 0, 0, 0, 0, 1);
            expect_out("mulrst", 0, 0, 0, 1, 0);
            idle(1);
            step(0, 1, 3, 1, 1, 1);  expect_out("add11", 1, 2, 0, 0, 0);
        end

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int op, a, b;
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, M - 1));
            b  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W + 2))
                                             : int'($urandom_range(0, M - 1));
            step(0, $urandom_range(0, 9) < 7, op, a, b, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
